// File: rtl/ex_operand_stage.sv
// ex_operand_stage: two-entry in-order operand buffer sitting between decode
// and the ALU. Operand forwarding from the MEM and WB buses is resolved once,
// in the cycle a beat is captured. Held entries are never re-forwarded, because
// upstream hazard logic stalls any dependent instruction. The head entry drives
// the ALU outputs directly from registers.
module ex_operand_stage (
   input  logic        clk,
   input  logic        rst,
   // decoded instruction in
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_alu_op,
   input  logic [4:0]  in_rs1_addr,
   input  logic [4:0]  in_rs2_addr,
   input  logic [31:0] in_rs1_data,
   input  logic [31:0] in_rs2_data,
   input  logic [31:0] in_imm,
   input  logic        in_use_imm,
   input  logic        in_use_pc,
   input  logic [31:0] in_pc,
   input  logic [4:0]  in_rd_addr,
   input  logic        in_reg_write,
   // forward buses
   input  logic        mem_fwd_en,
   input  logic [4:0]  mem_fwd_rd,
   input  logic [31:0] mem_fwd_data,
   input  logic        wb_fwd_en,
   input  logic [4:0]  wb_fwd_rd,
   input  logic [31:0] wb_fwd_data,
   // control
   input  logic        flush,
   // head entry out to the ALU
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_alu_op,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic [31:0] out_store_data,
   output logic [4:0]  out_rd_addr,
   output logic        out_reg_write,
   output logic [1:0]  occupancy
);

   // The encoding of each state is its entry count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   typedef struct packed {
      logic [4:0]  alu_op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] store_data;
      logic [4:0]  rd_addr;
      logic        reg_write;
   } entry_t;

   state_t state_q;
   state_t state_nxt;
   entry_t head_q;
   entry_t tail_q;
   entry_t new_entry;
   logic   in_ready_q;
   logic   accept;
   logic   retire;
   logic [31:0] rs1_fwd;
   logic [31:0] rs2_fwd;

   // Resolve one source operand. x0 always reads zero, and MEM is younger
   // than WB, so MEM wins when both buses match.
   function automatic logic [31:0] resolve_src(
      input logic [4:0]  rs,
      input logic [31:0] rf_data,
      input logic        m_en,
      input logic [4:0]  m_rd,
      input logic [31:0] m_data,
      input logic        w_en,
      input logic [4:0]  w_rd,
      input logic [31:0] w_data
   );
      logic [31:0] val;
      if (rs == 5'd0)
         val = 32'd0;
      else if (m_en && (m_rd == rs))
         val = m_data;
      else if (w_en && (w_rd == rs))
         val = w_data;
      else
         val = rf_data;
      return val;
   endfunction

   assign accept = in_valid && in_ready_q;
   assign retire = (state_q != EMPTY) && out_ready;

   assign rs1_fwd = resolve_src(in_rs1_addr, in_rs1_data, mem_fwd_en, mem_fwd_rd,
                                mem_fwd_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data);
   assign rs2_fwd = resolve_src(in_rs2_addr, in_rs2_data, mem_fwd_en, mem_fwd_rd,
                                mem_fwd_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data);

   // Build the entry that would be captured this cycle.
   always_comb begin
      new_entry.alu_op     = in_alu_op;
      new_entry.a          = in_use_pc  ? in_pc  : rs1_fwd;
      new_entry.b          = in_use_imm ? in_imm : rs2_fwd;
      new_entry.store_data = rs2_fwd;
      new_entry.rd_addr    = in_rd_addr;
      new_entry.reg_write  = in_reg_write;
   end

   // Next state: flush overrides accept and retire.
   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state_q;
      unique case (state_q)
         EMPTY: if (accept) state_nxt = ONE;
         ONE: begin
            if (accept && !retire)      state_nxt = TWO;
            else if (!accept && retire) state_nxt = EMPTY;
         end
         TWO:     if (retire) state_nxt = ONE;
         default: state_nxt = EMPTY;
      endcase
      if (flush) state_nxt = EMPTY;
   end

   // State, registered in_ready and entry storage. Reset has priority over
   // flush, accept and retire.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the values from before this edge.
      if (rst) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
         // NOTE: entries are only two registers deep and must read as zero
         // after reset, so they are reset along with the control state.
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         state_q    <= state_nxt;
         in_ready_q <= (state_nxt != TWO);
         if (!flush) begin
            unique case (state_q)
               EMPTY: if (accept) head_q <= new_entry;
               ONE: begin
                  if (accept && retire) head_q <= new_entry;
                  else if (accept)      tail_q <= new_entry;
               end
               TWO:     if (retire) head_q <= tail_q;
               default: ;
            endcase
         end
      end
   end

   assign in_ready       = in_ready_q;
   assign out_valid      = (state_q != EMPTY);
   assign occupancy      = state_q;
   assign out_alu_op     = head_q.alu_op;
   assign out_a          = head_q.a;
   assign out_b          = head_q.b;
   assign out_store_data = head_q.store_data;
   assign out_rd_addr    = head_q.rd_addr;
   // A stale head left behind after a retire or flush must never write the register file.
   assign out_reg_write  = head_q.reg_write && out_valid;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed testbench for ex_operand_stage. Inputs are driven 1ns after the
// rising edge and outputs are checked at that same point, after the edge has
// taken effect.
module tb_ex_operand_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_alu_op;
   logic [4:0]  in_rs1_addr, in_rs2_addr;
   logic [31:0] in_rs1_data, in_rs2_data;
   logic [31:0] in_imm;
   logic        in_use_imm, in_use_pc;
   logic [31:0] in_pc;
   logic [4:0]  in_rd_addr;
   logic        in_reg_write;
   logic        mem_fwd_en;
   logic [4:0]  mem_fwd_rd;
   logic [31:0] mem_fwd_data;
   logic        wb_fwd_en;
   logic [4:0]  wb_fwd_rd;
   logic [31:0] wb_fwd_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_alu_op;
   logic [31:0] out_a, out_b, out_store_data;
   logic [4:0]  out_rd_addr;
   logic        out_reg_write;
   logic [1:0]  occupancy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ex_operand_stage dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
      .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_imm(in_imm), .in_use_imm(in_use_imm), .in_use_pc(in_use_pc), .in_pc(in_pc),
      .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
      .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
      .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
      .out_a(out_a), .out_b(out_b), .out_store_data(out_store_data),
      .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write), .occupancy(occupancy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a register-sourced beat (no PC, no immediate).
   task automatic beat(input logic [4:0] op, input logic [4:0] rs1, input logic [31:0] d1,
                       input logic [4:0] rs2, input logic [31:0] d2,
                       input logic [4:0] rd, input logic wr);
      in_valid     = 1'b1;
      in_alu_op    = op;
      in_rs1_addr  = rs1;
      in_rs1_data  = d1;
      in_rs2_addr  = rs2;
      in_rs2_data  = d2;
      in_rd_addr   = rd;
      in_reg_write = wr;
      in_use_pc    = 1'b0;
      in_use_imm   = 1'b0;
   endtask

   task automatic no_fwd();
      mem_fwd_en = 1'b0; mem_fwd_rd = 5'd0; mem_fwd_data = 32'd0;
      wb_fwd_en  = 1'b0; wb_fwd_rd  = 5'd0; wb_fwd_data  = 32'd0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      in_valid = 1'b0; in_alu_op = '0; in_rs1_addr = '0; in_rs2_addr = '0;
      in_rs1_data = '0; in_rs2_data = '0; in_imm = '0; in_use_imm = 1'b0;
      in_use_pc = 1'b0; in_pc = '0; in_rd_addr = '0; in_reg_write = 1'b0;
      no_fwd();
      #1;
      step();
      step();
      rst = 1'b0;

      // Reset state
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_occ", 32'(occupancy), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_a", out_a, 32'd0);
      check("rst_op", 32'(out_alu_op), 32'd0);
      check("rst_wr", 32'(out_reg_write), 32'd0);

      // Basic capture with one-cycle latency
      beat(5'd0, 5'd5, 32'd7, 5'd6, 32'd9, 5'd4, 1'b1);
      step();
      in_valid = 1'b0;
      check("b_valid", 32'(out_valid), 32'd1);
      check("b_a", out_a, 32'd7);
      check("b_b", out_b, 32'd9);
      check("b_occ", 32'(occupancy), 32'd1);
      check("b_rd", 32'(out_rd_addr), 32'd4);
      check("b_wr", 32'(out_reg_write), 32'd1);
      step();
      check("b_drain_occ", 32'(occupancy), 32'd0);
      check("b_drain_wr", 32'(out_reg_write), 32'd0);

      // Forwarding: MEM over WB on rs1, WB-only on rs2
      beat(5'd1, 5'd3, 32'h99, 5'd7, 32'h77, 5'd1, 1'b0);
      mem_fwd_en = 1'b1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'h11;
      wb_fwd_en  = 1'b1; wb_fwd_rd  = 5'd7; wb_fwd_data  = 32'h33;
      step();
      check("fwd_mem_a", out_a, 32'h11);
      check("fwd_wb_b", out_b, 32'h33);
      check("fwd_wb_st", out_store_data, 32'h33);
      // MEM and WB both match rs1: MEM wins
      beat(5'd1, 5'd3, 32'h99, 5'd8, 32'h44, 5'd1, 1'b0);
      wb_fwd_rd = 5'd3; wb_fwd_data = 32'h22;
      step();
      check("fwd_prio_a", out_a, 32'h11);
      check("fwd_prio_b", out_b, 32'h44);
      check("fwd_prio_occ", 32'(occupancy), 32'd1);
      // x0 reads zero even with both buses targeting rd 0; simultaneous
      // accept+retire keeps occupancy at one with the new beat at the head.
      beat(5'd2, 5'd0, 32'hDEAD, 5'd8, 32'h44, 5'd2, 1'b1);
      mem_fwd_rd = 5'd0; mem_fwd_data = 32'h11;
      wb_fwd_rd  = 5'd0; wb_fwd_data  = 32'h22;
      step();
      in_valid = 1'b0;
      no_fwd();
      check("x0_a", out_a, 32'd0);
      check("x0_op", 32'(out_alu_op), 32'd2);
      check("x0_occ", 32'(occupancy), 32'd1);
      step();
      check("x0_drain", 32'(occupancy), 32'd0);

      // Backpressure: three beats offered while the ALU stalls
      out_ready = 1'b0;
      beat(5'd1, 5'd9, 32'hA1, 5'd10, 32'hA2, 5'd1, 1'b1);
      step();
      check("bp1_occ", 32'(occupancy), 32'd1);
      check("bp1_ready", 32'(in_ready), 32'd1);
      beat(5'd2, 5'd9, 32'hB1, 5'd10, 32'hB2, 5'd2, 1'b1);
      step();
      check("bp2_occ", 32'(occupancy), 32'd2);
      check("bp2_ready", 32'(in_ready), 32'd0);
      check("bp2_head_a", out_a, 32'hA1);
      beat(5'd3, 5'd11, 32'hC1, 5'd12, 32'hC2, 5'd3, 1'b1);
      // A later bus match on a held entry's source must not alter it
      mem_fwd_en = 1'b1; mem_fwd_rd = 5'd9; mem_fwd_data = 32'hEE;
      step();
      check("bp3_occ", 32'(occupancy), 32'd2);
      check("bp3_stable_a", out_a, 32'hA1);
      check("bp3_stable_op", 32'(out_alu_op), 32'd1);
      no_fwd();
      out_ready = 1'b1;
      step();
      check("dr1_a", out_a, 32'hB1);
      check("dr1_op", 32'(out_alu_op), 32'd2);
      check("dr1_occ", 32'(occupancy), 32'd1);
      check("dr1_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      check("dr2_a", out_a, 32'hC1);
      check("dr2_op", 32'(out_alu_op), 32'd3);
      check("dr2_occ", 32'(occupancy), 32'd1);
      step();
      check("dr3_occ", 32'(occupancy), 32'd0);

      // PC and immediate operand selection, then fill to TWO
      out_ready = 1'b0;
      beat(5'd4, 5'd1, 32'h12, 5'd2, 32'h55, 5'd6, 1'b1);
      in_use_pc = 1'b1; in_pc = 32'h100;
      in_use_imm = 1'b1; in_imm = 32'hFFFFFFFC;
      step();
      check("sel_a", out_a, 32'h100);
      check("sel_b", out_b, 32'hFFFFFFFC);
      check("sel_st", out_store_data, 32'h55);
      beat(5'd5, 5'd1, 32'h12, 5'd2, 32'h34, 5'd7, 1'b1);
      step();
      check("full_occ", 32'(occupancy), 32'd2);

      // Flush in TWO with a beat offered
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      check("fl_valid", 32'(out_valid), 32'd0);
      check("fl_occ", 32'(occupancy), 32'd0);
      check("fl_ready", 32'(in_ready), 32'd1);
      check("fl_wr", 32'(out_reg_write), 32'd0);

      // Flush in ONE discards the concurrent input beat
      beat(5'd6, 5'd1, 32'h61, 5'd2, 32'h62, 5'd8, 1'b1);
      step();
      check("fl1_occ_pre", 32'(occupancy), 32'd1);
      beat(5'd7, 5'd1, 32'h71, 5'd2, 32'h72, 5'd9, 1'b1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      check("fl1_occ", 32'(occupancy), 32'd0);
      check("fl1_valid", 32'(out_valid), 32'd0);

      // Reset mid-transfer wins over an offered beat and clears entry fields
      beat(5'd8, 5'd1, 32'h81, 5'd2, 32'h82, 5'd10, 1'b1);
      step();
      check("rs_pre_occ", 32'(occupancy), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      check("rs_occ", 32'(occupancy), 32'd0);
      check("rs_valid", 32'(out_valid), 32'd0);
      check("rs_ready", 32'(in_ready), 32'd1);
      check("rs_a", out_a, 32'd0);
      check("rs_op", 32'(out_alu_op), 32'd0);
      check("rs_rd", 32'(out_rd_addr), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
